// File: rtl/clk_sched_pkg.sv
// Shared types and helpers for the clock-divider scheduler.
//  state_t   : scheduler FSM states
//  DIV_W     : width of the divider divide-count
//  DWELL_W   : width of the dwell edge counter
//  clamp_div : optional floor applied to a requested divide-count
package clk_sched_pkg;

  localparam int unsigned DIV_W   = 32;
  localparam int unsigned DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    ACTIVE    = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  function automatic logic [DIV_W-1:0] clamp_div(
    input logic [DIV_W-1:0] value,
    input logic [DIV_W-1:0] floor_val,
    input logic             enable
  );
    if (enable && (value < floor_val)) return floor_val;
    return value;
  endfunction

endpackage

// File: rtl/clk_sched_rr_arb.sv
// Combinational round-robin pick.
//  req    in  NUM_REQ          level requests
//  ptr    in  $clog2(NUM_REQ)  index with highest priority this pick
//  onehot out NUM_REQ          one-hot of the chosen requester
//  idx    out $clog2(NUM_REQ)  index of the chosen requester
//  valid  out 1                at least one request present
module clk_sched_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  int unsigned cand;

  // Scan from ptr upward with wrap; the first hit wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = (32'(ptr) + off) % NUM_REQ;
      if (!valid && req[ID_W'(cand)]) begin
        valid                = 1'b1;
        idx                  = ID_W'(cand);
        onehot[ID_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_scheduler.sv
// Shares the divide-count input of the programmable clock divider between
// NUM_REQ requesters. Round-robin grant; a granted value is applied on the
// cycle after a divider output rising edge, then held for DWELL_EDGES edges
// (0 = until the requester drops its request).
// Optional feature: define CLK_SCHED_CLAMP_EN to floor latched values at MIN_DIV.
//  inclk          in   1                 system clock
//  Reset          in   1                 async active-low reset
//  req            in   NUM_REQ           level request per requester
//  div_req_value  in   NUM_REQ*32        requester i value at [32*i+:32]
//  outclk_mon     in   1                 divider outclk, synchronous to inclk
//  gnt            out  NUM_REQ           one-hot grant, registered
//  active_id      out  $clog2(NUM_REQ)   index of granted requester
//  busy           out  1                 high whenever not IDLE
//  div_load       out  1                 1-cycle pulse when div_clk_count updates
//  div_clk_count  out  32                divide-count to the divider
module clk_div_scheduler
  import clk_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter logic [31:0] DEFAULT_DIV = 32'd1,
  parameter logic [15:0] DWELL_EDGES = 16'd0,
  parameter logic [31:0] MIN_DIV     = 32'd1
) (
  input  logic                       inclk,
  input  logic                       Reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*32-1:0]      div_req_value,
  input  logic                       outclk_mon,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] active_id,
  output logic                       busy,
  output logic                       div_load,
  output logic [31:0]                div_clk_count
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

`ifdef CLK_SCHED_CLAMP_EN
  localparam logic CLAMP_ON = 1'b1;
`else
  localparam logic CLAMP_ON = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, id_q, ptr_next;
  logic [DIV_W-1:0]     val_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic                 mon_q, mon_rise;
  logic                 req_held, dwell_done;
  logic                 take_grant, apply_div;

  logic [NUM_REQ-1:0]   arb_onehot;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;
  logic [DIV_W-1:0]     req_val [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_val[i] = div_req_value[DIV_W*i +: DIV_W];
    end
  end

  clk_sched_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .valid  (arb_valid)
  );

  assign mon_rise   = outclk_mon & ~mon_q;
  assign req_held   = req[id_q];
  assign dwell_done = (DWELL_EDGES != '0) && (cnt_q >= DWELL_EDGES);
  assign ptr_next   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  assign active_id  = id_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    apply_div  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d    = WAIT_EDGE;
          take_grant = 1'b1;
        end
      end
      WAIT_EDGE: begin
        // A drop wins over a coincident rising edge: nothing is applied.
        if (!req_held) begin
          state_d = RELEASE;
        end else if (mon_rise) begin
          state_d   = ACTIVE;
          apply_div = 1'b1;
        end
      end
      ACTIVE: begin
        if (!req_held || dwell_done) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      id_q          <= '0;
      val_q         <= '0;
      cnt_q         <= '0;
      mon_q         <= 1'b0;
      gnt           <= '0;
      div_load      <= 1'b0;
      div_clk_count <= DEFAULT_DIV;
    end else begin
      state_q  <= state_d;
      mon_q    <= outclk_mon;
      div_load <= apply_div;

      if (take_grant) begin
        id_q  <= arb_idx;
        val_q <= clamp_div(req_val[arb_idx], MIN_DIV, CLAMP_ON);
        gnt   <= arb_onehot;
      end else if (state_d == RELEASE) begin
        gnt <= '0;
      end

      if (apply_div) begin
        div_clk_count <= val_q;
        cnt_q         <= '0;
      end else if ((state_q == ACTIVE) && mon_rise && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (state_q == RELEASE) ptr_q <= ptr_next;
    end
  end

endmodule

// File: tb/tb_clk_div_scheduler.sv
module tb_clk_div_scheduler;

  logic         inclk = 1'b0;
  logic         Reset = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] div_req_value = '0;
  logic         outclk_mon = 1'b0;

  logic [3:0]   gnt_a, gnt_b;
  logic [1:0]   id_a, id_b;
  logic         busy_a, busy_b, load_a, load_b;
  logic [31:0]  cnt_a, cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  // dut_a holds until release; dut_b releases after 2 edges.
  clk_div_scheduler #(
    .NUM_REQ(4), .DEFAULT_DIV(32'd1), .DWELL_EDGES(16'd0), .MIN_DIV(32'd4)
  ) dut_a (
    .inclk(inclk), .Reset(Reset), .req(req), .div_req_value(div_req_value),
    .outclk_mon(outclk_mon), .gnt(gnt_a), .active_id(id_a), .busy(busy_a),
    .div_load(load_a), .div_clk_count(cnt_a)
  );

  clk_div_scheduler #(
    .NUM_REQ(4), .DEFAULT_DIV(32'd1), .DWELL_EDGES(16'd2), .MIN_DIV(32'd4)
  ) dut_b (
    .inclk(inclk), .Reset(Reset), .req(req), .div_req_value(div_req_value),
    .outclk_mon(outclk_mon), .gnt(gnt_b), .active_id(id_b), .busy(busy_b),
    .div_load(load_b), .div_clk_count(cnt_b)
  );

  always #5 inclk = ~inclk;

  // Divider output stand-in: toggles on negedges every mon_half inclk cycles.
  bit          mon_en = 1'b0;
  int unsigned mon_half = 3;
  int unsigned mon_ph = 0;
  initial forever begin
    @(negedge inclk);
    if (mon_en) begin
      mon_ph++;
      if (mon_ph >= mon_half) begin
        mon_ph = 0;
        outclk_mon = ~outclk_mon;
      end
    end
  end

  bit last_mon = 1'b0;
  bit rise = 1'b0;

  // rise: outclk_mon as seen at this edge went 0->1 relative to the previous edge.
  task automatic step();
    @(posedge inclk);
    #1;
    rise = outclk_mon && !last_mon;
    last_mon = outclk_mon;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    mon_en = 1'b0;
    mon_ph = 0;
    outclk_mon = 1'b0;
    req = '0;
    repeat (3) @(posedge inclk);
    #1;
    Reset = 1'b1;
    last_mon = 1'b0;
    rise = 1'b0;
  endtask

  function automatic int next_id(input logic [3:0] mask, input int p);
    for (int off = 0; off < 4; off++) begin
      int i;
      i = (p + off) % 4;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] exp_val(input logic [31:0] v);
`ifdef CLK_SCHED_CLAMP_EN
    return (v < 32'd4) ? 32'd4 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [3:0] onehot4(input int i);
    logic [3:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++; if (cnt_a !== 32'd1) $display("FAIL reset_cnt_a got %0d expected 1", cnt_a); else n_pass++;
    n_checks++; if (cnt_b !== 32'd1) $display("FAIL reset_cnt_b got %0d expected 1", cnt_b); else n_pass++;
    n_checks++; if (gnt_a !== 4'b0 || gnt_b !== 4'b0) $display("FAIL reset_gnt got %b/%b expected 0000", gnt_a, gnt_b); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_busy got %b/%b expected 0", busy_a, busy_b); else n_pass++;
    n_checks++; if (load_a !== 1'b0 || id_a !== 2'd0) $display("FAIL reset_load_id got %b/%0d expected 0/0", load_a, id_a); else n_pass++;
    repeat (3) step();
    n_checks++; if (busy_a !== 1'b0 || cnt_a !== 32'd1) $display("FAIL idle_hold got busy %b cnt %0d expected 0/1", busy_a, cnt_a); else n_pass++;
  endtask

  task automatic test_single_grant();
    int g_step;
    bit loaded;
    int n_loads;
    do_reset();
    for (int i = 0; i < 4; i++) div_req_value[32*i +: 32] = $urandom;
    div_req_value[64 +: 32] = 32'd50;
    mon_half = 3;
    mon_en = 1'b1;
    req = 4'b0100;
    g_step = -1;
    loaded = 1'b0;
    for (int k = 0; k < 60 && !loaded; k++) begin
      step();
      if (g_step < 0 && gnt_a != 4'b0) begin
        g_step = k;
        n_checks++; if (gnt_a !== 4'b0100 || id_a !== 2'd2) $display("FAIL grant2 got %b id %0d expected 0100 id 2", gnt_a, id_a); else n_pass++;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL grant2_busy got %b expected 1", busy_a); else n_pass++;
      end else if (g_step >= 0 && rise) begin
        loaded = 1'b1;
        n_checks++; if (load_a !== 1'b1) $display("FAIL load_after_rise got %b expected 1", load_a); else n_pass++;
        n_checks++; if (cnt_a !== 32'd50) $display("FAIL load_value got %0d expected 50", cnt_a); else n_pass++;
      end else if (load_a) begin
        n_checks++; $display("FAIL spurious_load got 1 expected 0 at step %0d", k);
      end
    end
    n_checks++; if (!loaded) $display("FAIL load_timeout got none expected load within 60 cycles"); else n_pass++;
    step();
    n_checks++; if (load_a !== 1'b0) $display("FAIL load_pulse_width got %b expected 0", load_a); else n_pass++;
    // Value is frozen at grant: later changes must not reach the divider.
    div_req_value[64 +: 32] = 32'd77;
    n_loads = 0;
    repeat (20) begin
      step();
      if (load_a) n_loads++;
    end
    n_checks++; if (cnt_a !== 32'd50 || n_loads != 0) $display("FAIL frozen_value got %0d loads %0d expected 50 loads 0", cnt_a, n_loads); else n_pass++;
    n_checks++; if (gnt_a !== 4'b0100 || busy_a !== 1'b1) $display("FAIL hold_until_drop got %b busy %b expected 0100 busy 1", gnt_a, busy_a); else n_pass++;
  endtask

  task automatic test_reset_mid();
    Reset = 1'b0;
    #1;
    n_checks++; if (gnt_a !== 4'b0 || busy_a !== 1'b0) $display("FAIL midreset_gnt_busy got %b/%b expected 0000/0", gnt_a, busy_a); else n_pass++;
    n_checks++; if (cnt_a !== 32'd1 || load_a !== 1'b0 || id_a !== 2'd0) $display("FAIL midreset_cnt got %0d load %b id %0d expected 1/0/0", cnt_a, load_a, id_a); else n_pass++;
    do_reset();
  endtask

  task automatic test_drop_on_rise();
    do_reset();
    div_req_value[32 +: 32] = 32'd123;
    req = 4'b0010;
    step();
    n_checks++; if (gnt_a !== 4'b0010) $display("FAIL drop_grant got %b expected 0010", gnt_a); else n_pass++;
    req = 4'b0000;
    outclk_mon = 1'b1;
    step();
    n_checks++; if (load_a !== 1'b0 || cnt_a !== 32'd1) $display("FAIL drop_beats_rise got load %b cnt %0d expected 0/1", load_a, cnt_a); else n_pass++;
    n_checks++; if (gnt_a !== 4'b0) $display("FAIL drop_gnt_clear got %b expected 0000", gnt_a); else n_pass++;
    step();
    n_checks++; if (busy_a !== 1'b0 || cnt_a !== 32'd1 || load_a !== 1'b0) $display("FAIL drop_idle got busy %b cnt %0d load %b expected 0/1/0", busy_a, cnt_a, load_a); else n_pass++;
    outclk_mon = 1'b0;
  endtask

  task automatic test_clamp();
    bit ok;
    do_reset();
    div_req_value[0 +: 32] = 32'd0;
    mon_half = 2;
    mon_en = 1'b1;
    req = 4'b0001;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (load_a) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL clamp_load_timeout got none expected load"); else n_pass++;
    n_checks++; if (cnt_a !== exp_val(32'd0)) $display("FAIL clamp_value got %0d expected %0d", cnt_a, exp_val(32'd0)); else n_pass++;
    req = 4'b0000;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!busy_a) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL release_timeout got busy expected idle"); else n_pass++;
    n_checks++; if (cnt_a !== exp_val(32'd0) || gnt_a !== 4'b0) $display("FAIL retain_after_release got %0d gnt %b expected %0d gnt 0000", cnt_a, gnt_a, exp_val(32'd0)); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0]  mask;
    logic [31:0] vals [4];
    int ptr_m, exp_id, n_grants, n_rise;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      mask = (r == 0) ? 4'b1111 : 4'($urandom_range(1, 15));
      n_grants = (r == 0) ? 5 : 4;
      for (int i = 0; i < 4; i++) begin
        vals[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        div_req_value[32*i +: 32] = vals[i];
      end
      mon_half = $urandom_range(2, 4);
      mon_en = 1'b1;
      req = mask;
      ptr_m = 0;
      for (int g = 0; g < n_grants; g++) begin
        exp_id = next_id(mask, ptr_m);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
          step();
          if (gnt_b != 4'b0) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || gnt_b !== onehot4(exp_id) || id_b !== 2'(exp_id)) $display("FAIL rr_order r%0d g%0d got %b id %0d expected %b", r, g, gnt_b, id_b, onehot4(exp_id)); else n_pass++;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
          step();
          if (load_b) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok || cnt_b !== exp_val(vals[exp_id])) $display("FAIL rr_value r%0d g%0d got %0h expected %0h", r, g, cnt_b, exp_val(vals[exp_id])); else n_pass++;
        n_rise = 0;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
          step();
          if (gnt_b == 4'b0) begin ok = 1'b1; break; end
          if (rise) n_rise++;
        end
        n_checks++; if (!ok || n_rise != 2) $display("FAIL rr_dwell r%0d g%0d got %0d edges expected 2", r, g, n_rise); else n_pass++;
        ptr_m = (exp_id + 1) % 4;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    div_req_value[96 +: 32] = $urandom;
    mon_half = 2;
    mon_en = 1'b1;
    req = 4'b1000;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (load_b) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) $display("FAIL b2b_load_timeout got none expected load"); else n_pass++;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (gnt_b == 4'b0) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok || busy_b !== 1'b1) $display("FAIL b2b_release got ok %b busy %b expected 1/1", ok, busy_b); else n_pass++;
    step();
    n_checks++; if (gnt_b !== 4'b0 || busy_b !== 1'b0) $display("FAIL b2b_idle got %b busy %b expected 0000 busy 0", gnt_b, busy_b); else n_pass++;
    step();
    n_checks++; if (gnt_b !== 4'b1000 || busy_b !== 1'b1 || id_b !== 2'd3) $display("FAIL b2b_regrant got %b busy %b id %0d expected 1000/1/3", gnt_b, busy_b, id_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_reset_mid();
    test_drop_on_rise();
    test_clamp();
    test_round_robin();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
